// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its debounce stage.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    STEADY,
    ERROR
  } db_state_t;

  // Saturate a 5-bit incremented count back into a 4-bit counter.
  function automatic logic [3:0] sat_inc4(input logic [4:0] v);
    return (v > 5'd15) ? 4'd15 : v[3:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives a settled copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces the row bus for the column currently driven by the scanner.
module keypad_debouncer #(
  parameter int unsigned TICK_DIV = 4096,
  parameter int unsigned ROW_W    = keypad_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROW_W-1:0] R_raw,
  input  logic             db_en,
  input  logic [3:0]       db_criterion,
  input  logic [3:0]       db_fail_criterion,
  output logic             db_steady,
  output logic             db_error,
  output logic [ROW_W-1:0] R_db
);

  import keypad_pkg::*;

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  db_state_t        state;
  logic [ROW_W-1:0] r_s;
  logic [ROW_W-1:0] ref_q;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       stable_q;
  logic [3:0]       fail_q;
  logic             tick;
  logic [4:0]       stable_inc;
  logic [4:0]       fail_inc;
  logic [4:0]       need;

  sync_2ff #(.W(ROW_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (R_raw),
    .q     (r_s)
  );

  // A zero criterion still needs one matching tick; compare in 5 bits so +1 never wraps.
  assign tick       = (state == SAMPLE) && (tick_cnt == TICK_LAST);
  assign stable_inc = {1'b0, stable_q} + 5'd1;
  assign fail_inc   = {1'b0, fail_q} + 5'd1;
  assign need       = (db_criterion == 4'd0) ? 5'd1 : {1'b0, db_criterion};

  // Sample-tick prescaler: runs only while sampling so the first tick lands TICK_DIV cycles in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (state != SAMPLE) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Debounce FSM with stable/fail counters and registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ref_q     <= '0;
      stable_q  <= '0;
      fail_q    <= '0;
      db_steady <= 1'b0;
      db_error  <= 1'b0;
      R_db      <= '0;
    end else if (!db_en) begin
      state     <= IDLE;
      db_steady <= 1'b0;
      db_error  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ref_q    <= r_s;
          stable_q <= '0;
          fail_q   <= '0;
          state    <= SAMPLE;
        end
        SAMPLE: begin
          if (tick) begin
            if (r_s == ref_q) begin
              stable_q <= sat_inc4(stable_inc);
              if (stable_inc >= need) begin
                R_db      <= ref_q;
                db_steady <= 1'b1;
                state     <= STEADY;
              end
            end else begin
              ref_q    <= r_s;
              stable_q <= '0;
              fail_q   <= sat_inc4(fail_inc);
              if ((db_fail_criterion != 4'd0) && (fail_inc >= {1'b0, db_fail_criterion})) begin
                db_error <= 1'b1;
                state    <= ERROR;
              end
            end
          end
        end
        STEADY, ERROR: begin
        end
      endcase
    end
  end

endmodule
